// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional frame locking (req_last) is compiled in with `define UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned DONE_TIMEOUT = 65535
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           tx_start,
  output logic [DATA_BITS-1:0]           tx_data,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic                           timeout_err
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]           state, state_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic [DATA_BITS-1:0] tx_data_d;
  logic                 tx_start_d, timeout_d;
  logic [PTR_W-1:0]     last, last_d;
  logic                 lock, lock_d;
  logic [CNT_W-1:0]     cnt, cnt_d;

  logic [NUM_REQ-1:0]   cand;
  logic                 found;
  logic [PTR_W-1:0]     win, pos;
  logic                 wd_expire;

  // Round-robin scan starting just after the previous owner
  always_comb begin
    cand = req_valid;
`ifdef UART_ARB_LOCK_EN
    if (lock) cand = req_valid & (NUM_REQ'(1) << last);
`endif
    found = 1'b0;
    win   = last;
    pos   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      pos = PTR_W'((32'(last) + k) % NUM_REQ);
      if (!found && cand[pos]) begin
        found = 1'b1;
        win   = pos;
      end
    end
  end

`ifndef UART_ARB_LOCK_EN
  logic unused_last;
  assign unused_last = ^req_last;
`endif

  assign wd_expire = (DONE_TIMEOUT != 0) && (cnt == CNT_W'(DONE_TIMEOUT - 1));
  assign req_ready = (rst_n && state == IDLE && found) ? (NUM_REQ'(1) << win) : '0;

  // Next-state and registered-output values
  always_comb begin
    state_d    = state;
    grant_d    = grant;
    tx_data_d  = tx_data;
    last_d     = last;
    lock_d     = lock;
    cnt_d      = cnt;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          tx_data_d  = req_data[win*DATA_BITS +: DATA_BITS];
          grant_d    = NUM_REQ'(1) << win;
          last_d     = win;
          tx_start_d = 1'b1;
          state_d    = START;
`ifdef UART_ARB_LOCK_EN
          lock_d     = ~req_last[win];
`else
          lock_d     = 1'b0;
`endif
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        cnt_d = cnt + CNT_W'(1);
        // Completion beats a watchdog expiry in the same cycle
        if (tx_done) begin
          state_d = IDLE;
          if (!lock) grant_d = '0;
        end else if (wd_expire) begin
          state_d   = IDLE;
          grant_d   = '0;
          lock_d    = 1'b0;
          timeout_d = 1'b1;
        end else if (state == WAIT_BUSY && tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      last        <= PTR_W'(NUM_REQ - 1);
      lock        <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      tx_data     <= tx_data_d;
      tx_start    <= tx_start_d;
      timeout_err <= timeout_d;
      last        <= last_d;
      lock        <= lock_d;
      cnt         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural transmitter model.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready, grant;
  logic        tx_start, tx_busy, tx_done, timeout_err;
  logic [7:0]  tx_data;

  logic [3:0]  req_ready0, grant0;
  logic        tx_start0, timeout_err0;
  logic [7:0]  tx_data0;
  logic        tx_busy0, tx_done0;

  int total = 0;
  int bad   = 0;

  int busy_dly, done_dly;
  bit m_hang;
  bit m_run;
  int m_cnt;

  logic [7:0] sent_q[$];
  logic       overlap  = 1'b0;
  logic       to0_seen = 1'b0;
  wire        unused_tb = ^{req_ready0, tx_start0, tx_data0};

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .DONE_TIMEOUT(50)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done), .timeout_err(timeout_err));

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .DONE_TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready0), .grant(grant0), .tx_start(tx_start0),
    .tx_data(tx_data0), .tx_busy(tx_busy0), .tx_done(tx_done0), .timeout_err(timeout_err0));

  always #5 clk = ~clk;

  // Transmitter model: busy busy_dly cycles after start, done pulse after done_dly
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      m_run   <= 1'b0;
      m_cnt   <= 0;
    end else begin
      tx_done <= 1'b0;
      if (tx_start) begin
        m_run <= 1'b1;
        m_cnt <= 1;
      end else if (timeout_err) begin
        m_run   <= 1'b0;
        tx_busy <= 1'b0;
      end else if (m_run) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == busy_dly) tx_busy <= 1'b1;
        if (m_cnt == done_dly && !m_hang) begin
          tx_done <= 1'b1;
          tx_busy <= 1'b0;
          m_run   <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (tx_start) sent_q.push_back(tx_data);
      if (tx_start && tx_busy) overlap <= 1'b1;
      if (timeout_err0) to0_seen <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (tx_start !== 1'b1 && n < 500) begin step(); n++; end
    total++;
    if (tx_start !== 1'b1) begin bad++; $display("FAIL %s_start_wait: tx_start never rose", tag); end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (tx_done !== 1'b1 && n < 500) begin step(); n++; end
    total++;
    if (tx_done !== 1'b1) begin bad++; $display("FAIL %s_done_wait: tx_done never rose", tag); end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (grant !== 4'b0000 && n < 500) begin step(); n++; end
    total++;
    if (grant !== 4'b0000) begin bad++; $display("FAIL %s_idle_wait: grant=%b req 0000", tag, grant); end
  endtask

  task automatic do_reset();
    req_valid = 4'b0000;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    #2;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rst_grant: got %b req 0000", grant); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start: got %b req 0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h req 00", tx_data); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b req 0", timeout_err); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready: got %b req 0000", req_ready); end
    req_valid = 4'b0000;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    bit hold = 1'b1;
    int n = 0;
    busy_dly = 2; done_dly = 30;
    req_data[7:0] = 8'hA5; req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready: got %b req 0001", req_ready); end
    step();
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start: got %b req 1", tx_start); end
    total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_data: got %h req a5", tx_data); end
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b req 0001", grant); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_off: got %b req 0000", req_ready); end
    req_valid = 4'b0000;
    step();
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_pulse: got %b req 0", tx_start); end
    while (tx_done !== 1'b1 && n < 200) begin
      if (grant !== 4'b0001) hold = 1'b0;
      step(); n++;
    end
    total++; if (tx_done !== 1'b1) begin bad++; $display("FAIL single_done_wait: tx_done never rose"); end
    total++; if (hold !== 1'b1) begin bad++; $display("FAIL single_grant_hold: got %b req 1", hold); end
    step();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_release: got %b req 0000", grant); end
  endtask

  task automatic test_fast();
    busy_dly = 50; done_dly = 1;
    req_data[23:16] = 8'h3D; req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL fast_ready: got %b req 0100", req_ready); end
    wait_start("fast");
    total++; if (tx_data !== 8'h3D) begin bad++; $display("FAIL fast_data: got %h req 3d", tx_data); end
    req_valid = 4'b0000;
    wait_done("fast");
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL fast_grant: got %b req 0100", grant); end
    step();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL fast_release: got %b req 0000", grant); end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_b [5];
    int n = 0;
    exp_b[0] = 8'h10; exp_b[1] = 8'h21; exp_b[2] = 8'h32; exp_b[3] = 8'h43; exp_b[4] = 8'h10;
    do_reset();
    busy_dly = 2; done_dly = 8;
    req_data = 32'h4332_2110;
    sent_q.delete();
    req_valid = 4'b1111;
    while (sent_q.size() < 5 && n < 1000) begin step(); n++; end
    req_valid = 4'b0000;
    total++; if (sent_q.size() < 5) begin bad++; $display("FAIL fair_count: got %0d req 5", sent_q.size()); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (sent_q.size() <= i || sent_q[i] !== exp_b[i]) begin
        bad++; $display("FAIL fair_order[%0d]: got %h req %h", i, (sent_q.size() > i) ? sent_q[i] : 8'hxx, exp_b[i]);
      end
    end
    wait_idle("fair");
  endtask

  task automatic test_back_to_back();
    busy_dly = 2; done_dly = 8;
    req_data[7:0] = 8'h5E; req_data[15:8] = 8'h6F;
    req_valid = 4'b0011;
    wait_start("b2b");
    total++; if (tx_data !== 8'h6F) begin bad++; $display("FAIL b2b_first: got %h req 6f", tx_data); end
    req_valid = 4'b0001;
    wait_done("b2b");
    step();
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL b2b_m1_start: got %b req 0", tx_start); end
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL b2b_m1_ready: got %b req 0001", req_ready); end
    step();
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL b2b_m2_start: got %b req 1", tx_start); end
    total++; if (tx_data !== 8'h5E) begin bad++; $display("FAIL b2b_m2_data: got %h req 5e", tx_data); end
    req_valid = 4'b0000;
    wait_idle("b2b");
    total++; if (overlap !== 1'b0) begin bad++; $display("FAIL b2b_overlap: got %b req 0", overlap); end
  endtask

  task automatic test_watchdog();
    bit early = 1'b0;
    do_reset();
    m_hang = 1'b1; busy_dly = 2; done_dly = 8;
    req_data[7:0] = 8'h66; req_data[15:8] = 8'h77;
    req_valid = 4'b0011;
    wait_start("wd");
    total++; if (tx_data !== 8'h66) begin bad++; $display("FAIL wd_first: got %h req 66", tx_data); end
    for (int k = 1; k <= 52; k++) begin
      step();
      if (k <= 50 && timeout_err !== 1'b0) early = 1'b1;
      if (k == 51) begin
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL wd_pulse: got %b req 1", timeout_err); end
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL wd_grant: got %b req 0000", grant); end
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wd_next_ready: got %b req 0010", req_ready); end
        m_hang = 1'b0;
      end
      if (k == 52) begin
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL wd_pulse_end: got %b req 0", timeout_err); end
        total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL wd_restart: got %b req 1", tx_start); end
        total++; if (tx_data !== 8'h77) begin bad++; $display("FAIL wd_next_data: got %h req 77", tx_data); end
        req_valid = 4'b0000;
      end
    end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL wd_early: got %b req 0", early); end
    wait_idle("wd");
  endtask

  task automatic test_done_vs_timeout();
    busy_dly = 2; done_dly = 49;
    req_data[7:0] = 8'h99; req_valid = 4'b0001;
    wait_start("tie");
    total++; if (tx_data !== 8'h99) begin bad++; $display("FAIL tie_data: got %h req 99", tx_data); end
    req_valid = 4'b0000;
    for (int k = 1; k <= 51; k++) begin
      step();
      if (k == 50) begin
        total++; if (tx_done !== 1'b1) begin bad++; $display("FAIL tie_done: got %b req 1", tx_done); end
      end
      if (k == 51) begin
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tie_timeout: got %b req 0", timeout_err); end
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL tie_grant: got %b req 0000", grant); end
      end
    end
  endtask

  task automatic test_reset_mid();
    busy_dly = 2; done_dly = 30;
    req_data[7:0] = 8'h11; req_data[15:8] = 8'h22; req_data[23:16] = 8'hC3;
    req_valid = 4'b0100;
    wait_start("rmid");
    total++; if (tx_data !== 8'hC3) begin bad++; $display("FAIL rmid_data: got %h req c3", tx_data); end
    req_valid = 4'b0000;
    repeat (10) step();
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL rmid_grant_pre: got %b req 0100", grant); end
    req_valid = 4'b0011;
    rst_n = 1'b0;
    #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rmid_grant: got %b req 0000", grant); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rmid_start: got %b req 0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rmid_txdata: got %h req 00", tx_data); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rmid_ready: got %b req 0000", req_ready); end
    step(); step();
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_first: got %b req 0001", req_ready); end
    step();
    total++; if (tx_start !== 1'b1 || tx_data !== 8'h11) begin
      bad++; $display("FAIL rmid_restart: start=%b data=%h req 1/11", tx_start, tx_data);
    end
    req_valid = 4'b0000;
    wait_idle("rmid");
  endtask

  task automatic test_lock();
    logic [7:0] exp_b [3];
    logic [3:0] exp_gap, gap_grant, rdy;
    bit r1_idx = 1'b0, first_done = 1'b0, cap = 1'b0;
`ifdef UART_ARB_LOCK_EN
    exp_b[0] = 8'hB4; exp_b[1] = 8'h3C; exp_b[2] = 8'h5A; exp_gap = 4'b0010;
`else
    exp_b[0] = 8'hB4; exp_b[1] = 8'h5A; exp_b[2] = 8'h3C; exp_gap = 4'b0000;
`endif
    gap_grant = 4'bxxxx;
    busy_dly = 2; done_dly = 8;
    req_data[7:0] = 8'h5A; req_data[15:8] = 8'hB4;
    req_last = 4'b1101;
    sent_q.delete();
    req_valid = 4'b0011;
    #1;
    for (int n = 0; n < 600; n++) begin
      rdy = req_ready;
      step();
      if (cap) begin gap_grant = grant; cap = 1'b0; end
      if (tx_done === 1'b1 && !first_done) begin first_done = 1'b1; cap = 1'b1; end
      if (rdy[1]) begin
        if (!r1_idx) begin req_data[15:8] = 8'h3C; req_last[1] = 1'b1; r1_idx = 1'b1; end
        else req_valid[1] = 1'b0;
      end
      if (rdy[0]) req_valid[0] = 1'b0;
      #1;
      if (sent_q.size() >= 3) break;
    end
    req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (sent_q.size() <= i || sent_q[i] !== exp_b[i]) begin
        bad++; $display("FAIL lock_order[%0d]: got %h req %h", i, (sent_q.size() > i) ? sent_q[i] : 8'hxx, exp_b[i]);
      end
    end
    wait_idle("lock");
    total++; if (gap_grant !== exp_gap) begin bad++; $display("FAIL lock_gap_grant: got %b req %b", gap_grant, exp_gap); end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    req_valid = 4'b0000; req_data = 32'h0; req_last = 4'b1111;
    tx_busy0 = 1'b1; tx_done0 = 1'b0;
    busy_dly = 2; done_dly = 30; m_hang = 1'b0;
    test_reset();
    test_single();
    test_fast();
    test_fairness();
    test_back_to_back();
    test_watchdog();
    test_done_vs_timeout();
    test_reset_mid();
    test_lock();
    total++; if (to0_seen !== 1'b0) begin bad++; $display("FAIL nowd_pulse: got %b req 0", to0_seen); end
    total++; if (grant0 !== 4'b0001) begin bad++; $display("FAIL nowd_hold: got %b req 0001", grant0); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: sim time %0t req under 1000000", $time);
    $fatal(1, "bench timed out");
  end

endmodule
